wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_wb_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: three result sources, each with a private 2-entry FIFO, share one output register.
// Define WB_ARB_FIXED_PRIO_EN for fixed priority BR > LSU > ALU; round-robin ALU->LSU->BR otherwise.
module wb_arbiter #(
    parameter int PREG_W = 6,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,

    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic [TAG_W-1:0]  alu_tag_i,
    input  logic [PREG_W-1:0] alu_rd_i,
    input  logic [31:0]       alu_val_i,

    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [TAG_W-1:0]  lsu_tag_i,
    input  logic [PREG_W-1:0] lsu_rd_i,
    input  logic [31:0]       lsu_val_i,

    input  logic              br_valid_i,
    output logic              br_ready_o,
    input  logic [TAG_W-1:0]  br_tag_i,
    input  logic [PREG_W-1:0] br_rd_i,
    input  logic [31:0]       br_val_i,
    input  logic              br_mispredict_i,

    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [TAG_W-1:0]  wb_tag_o,
    output logic [PREG_W-1:0] wb_rd_o,
    output logic [31:0]       wb_val_o,
    output logic [1:0]        wb_src_fu_o,
    output logic              wb_mispredict_o,
    output logic              wb_completed_o
);

    // Entry layout: {mispredict, tag, rd, value}
    localparam int ENT_W = 1 + TAG_W + PREG_W + 32;
    localparam int NSRC  = 3;

    logic [ENT_W-1:0] in_ent [NSRC];
    logic [ENT_W-1:0] head   [NSRC];
    logic [ENT_W-1:0] mem    [NSRC][2];
    logic [1:0]       count  [NSRC];
    logic [NSRC-1:0]  in_valid;
    logic [NSRC-1:0]  src_ready;
    logic [NSRC-1:0]  push;
    logic [NSRC-1:0]  pop;
    logic [NSRC-1:0]  avail;
    logic [NSRC-1:0]  rd_ptr;
    logic [NSRC-1:0]  wr_ptr;
    logic             ready_en;

    logic             out_valid;
    logic [ENT_W-1:0] out_ent;
    logic [1:0]       out_src;

    logic             load;
    logic             gnt_valid;
    logic [1:0]       gnt_idx;

    // Source handshakes. An empty FIFO forwards its incoming entry as the head so an
    // idle arbiter can load a result on the same edge it is accepted.
    always_comb begin
        in_valid  = {br_valid_i, lsu_valid_i, alu_valid_i};
        in_ent[0] = {1'b0, alu_tag_i, alu_rd_i, alu_val_i};
        in_ent[1] = {1'b0, lsu_tag_i, lsu_rd_i, lsu_val_i};
        in_ent[2] = {br_mispredict_i, br_tag_i, br_rd_i, br_val_i};
        src_ready = '0;
        push      = '0;
        avail     = '0;
        for (int s = 0; s < NSRC; s++) begin
            src_ready[s] = ready_en && (count[s] != 2'd2);
            push[s]      = in_valid[s] && src_ready[s] && !flush_i;
            avail[s]     = (count[s] != 2'd0) || push[s];
            head[s]      = (count[s] == 2'd0) ? in_ent[s] : mem[s][rd_ptr[s]];
        end
    end

    assign load = !out_valid || wb_ready_i;

`ifdef WB_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_valid = 1'b1;
        gnt_idx   = 2'd0;
        if (avail[2])      gnt_idx = 2'd2;
        else if (avail[1]) gnt_idx = 2'd1;
        else if (avail[0]) gnt_idx = 2'd0;
        else               gnt_valid = 1'b0;
    end
`else
    logic [1:0] rr_ptr;
    logic [2:0] cand;

    // Search starting at the pointer, wrapping ALU->LSU->BR.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 2'd0;
        cand      = 3'd0;
        for (int i = 0; i < NSRC; i++) begin
            cand = {1'b0, rr_ptr} + 3'(i);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (!gnt_valid && avail[cand[1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 2'd0;
        end else if (load && gnt_valid && !flush_i) begin
            rr_ptr <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
        end
    end
`endif

    always_comb begin
        pop = '0;
        for (int s = 0; s < NSRC; s++) begin
            pop[s] = load && gnt_valid && !flush_i && (gnt_idx == 2'(s));
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NSRC; s++) begin
            if (push[s]) mem[s][wr_ptr[s]] <= in_ent[s];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_en  <= 1'b0;
            out_valid <= 1'b0;
            out_ent   <= '0;
            out_src   <= 2'd0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            for (int s = 0; s < NSRC; s++) count[s] <= 2'd0;
        end else begin
            ready_en <= 1'b1;
            if (flush_i) begin
                // Pointers realign so an empty FIFO keeps rd_ptr == wr_ptr.
                out_valid <= 1'b0;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                for (int s = 0; s < NSRC; s++) count[s] <= 2'd0;
            end else begin
                rd_ptr <= rd_ptr ^ pop;
                wr_ptr <= wr_ptr ^ push;
                for (int s = 0; s < NSRC; s++) begin
                    count[s] <= count[s] + 2'(push[s]) - 2'(pop[s]);
                end
                if (load) begin
                    out_valid <= gnt_valid;
                    if (gnt_valid) begin
                        out_ent <= head[gnt_idx];
                        out_src <= gnt_idx;
                    end
                end
            end
        end
    end

    assign alu_ready_o     = src_ready[0];
    assign lsu_ready_o     = src_ready[1];
    assign br_ready_o      = src_ready[2];
    assign wb_valid_o      = out_valid;
    assign wb_completed_o  = out_valid;
    assign wb_mispredict_o = out_ent[ENT_W-1];
    assign wb_tag_o        = out_ent[ENT_W-2 -: TAG_W];
    assign wb_rd_o         = out_ent[32 +: PREG_W];
    assign wb_val_o        = out_ent[31:0];
    assign wb_src_fu_o     = out_src;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic checked by per-source expected queues.
// Expected arbitration order follows WB_ARB_FIXED_PRIO_EN when defined.
module tb_wb_arbiter;
    localparam int TAG_W  = 4;
    localparam int PREG_W = 6;
    localparam int EW     = 1 + TAG_W + PREG_W + 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush_i = 1'b0;
    logic              alu_valid_i = 1'b0, lsu_valid_i = 1'b0, br_valid_i = 1'b0;
    logic              alu_ready_o, lsu_ready_o, br_ready_o;
    logic [TAG_W-1:0]  alu_tag_i = '0, lsu_tag_i = '0, br_tag_i = '0;
    logic [PREG_W-1:0] alu_rd_i = '0, lsu_rd_i = '0, br_rd_i = '0;
    logic [31:0]       alu_val_i = '0, lsu_val_i = '0, br_val_i = '0;
    logic              br_mispredict_i = 1'b0;
    logic              wb_valid_o, wb_ready_i = 1'b0;
    logic [TAG_W-1:0]  wb_tag_o;
    logic [PREG_W-1:0] wb_rd_o;
    logic [31:0]       wb_val_o;
    logic [1:0]        wb_src_fu_o;
    logic              wb_mispredict_o, wb_completed_o;

    wb_arbiter #(.PREG_W(PREG_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_tag_i(alu_tag_i),
        .alu_rd_i(alu_rd_i), .alu_val_i(alu_val_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_tag_i(lsu_tag_i),
        .lsu_rd_i(lsu_rd_i), .lsu_val_i(lsu_val_i),
        .br_valid_i(br_valid_i), .br_ready_o(br_ready_o), .br_tag_i(br_tag_i),
        .br_rd_i(br_rd_i), .br_val_i(br_val_i), .br_mispredict_i(br_mispredict_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_tag_o(wb_tag_o),
        .wb_rd_o(wb_rd_o), .wb_val_o(wb_val_o), .wb_src_fu_o(wb_src_fu_o),
        .wb_mispredict_o(wb_mispredict_o), .wb_completed_o(wb_completed_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    int vectors = 0;
    int miscompares = 0;

    logic [EW-1:0] exp_q_alu[$];
    logic [EW-1:0] exp_q_lsu[$];
    logic [EW-1:0] exp_q_br[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard feed: record accepted results just before the edge that accepts them.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (reset || flush_i) begin
                exp_q_alu.delete();
                exp_q_lsu.delete();
                exp_q_br.delete();
            end else begin
                if (alu_valid_i && alu_ready_o) exp_q_alu.push_back({1'b0, alu_tag_i, alu_rd_i, alu_val_i});
                if (lsu_valid_i && lsu_ready_o) exp_q_lsu.push_back({1'b0, lsu_tag_i, lsu_rd_i, lsu_val_i});
                if (br_valid_i && br_ready_o)
                    exp_q_br.push_back({br_mispredict_i, br_tag_i, br_rd_i, br_val_i});
            end
        end
    end

    // Monitor: compare each delivered packet and stall stability.
    logic          hold_pend = 1'b0;
    logic [EW-1:0] hold_pkt;
    logic [1:0]    hold_src;

    always @(negedge clk) begin
        logic [EW-1:0] pkt;
        logic [EW-1:0] exp_pkt;
        int            qsize;
        pkt = {wb_mispredict_o, wb_tag_o, wb_rd_o, wb_val_o};
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            check("completed_eq_valid", 64'(wb_completed_o), 64'(wb_valid_o));
            if (hold_pend) begin
                check("stall_valid", 64'(wb_valid_o), 64'd1);
                check("stall_pkt", 64'(pkt), 64'(hold_pkt));
                check("stall_src", 64'(wb_src_fu_o), 64'(hold_src));
            end
            if (wb_valid_o && wb_ready_i) begin
                exp_pkt = '0;
                case (wb_src_fu_o)
                    2'd0: begin qsize = exp_q_alu.size(); if (qsize > 0) exp_pkt = exp_q_alu.pop_front(); end
                    2'd1: begin qsize = exp_q_lsu.size(); if (qsize > 0) exp_pkt = exp_q_lsu.pop_front(); end
                    2'd2: begin qsize = exp_q_br.size();  if (qsize > 0) exp_pkt = exp_q_br.pop_front(); end
                    default: qsize = 0;
                endcase
                if (qsize == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pkt: src %0d tag 0x%0h delivered, required no packet at %0t",
                             wb_src_fu_o, wb_tag_o, $time);
                end else begin
                    check("pkt_fields", 64'(pkt), 64'(exp_pkt));
                end
            end
            hold_pend = wb_valid_o && !wb_ready_i && !flush_i;
            hold_pkt  = pkt;
            hold_src  = wb_src_fu_o;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        alu_valid_i = 1'b0;
        lsu_valid_i = 1'b0;
        br_valid_i = 1'b0;
        br_mispredict_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic drive(input int s, input logic [TAG_W-1:0] tag, input logic [PREG_W-1:0] rd,
                         input logic [31:0] val, input logic mis);
        case (s)
            0: begin alu_valid_i = 1'b1; alu_tag_i = tag; alu_rd_i = rd; alu_val_i = val; end
            1: begin lsu_valid_i = 1'b1; lsu_tag_i = tag; lsu_rd_i = rd; lsu_val_i = val; end
            default: begin
                br_valid_i = 1'b1; br_tag_i = tag; br_rd_i = rd; br_val_i = val; br_mispredict_i = mis;
            end
        endcase
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tagname);
        check({tagname, "_valid"}, 64'(wb_valid_o), 64'd0);
        check({tagname, "_completed"}, 64'(wb_completed_o), 64'd0);
        check({tagname, "_tag"}, 64'(wb_tag_o), 64'd0);
        check({tagname, "_rd"}, 64'(wb_rd_o), 64'd0);
        check({tagname, "_val"}, 64'(wb_val_o), 64'd0);
        check({tagname, "_src"}, 64'(wb_src_fu_o), 64'd0);
        check({tagname, "_mis"}, 64'(wb_mispredict_o), 64'd0);
    endtask

    int ord [3];

    initial begin
`ifdef WB_ARB_FIXED_PRIO_EN
        ord[0] = 3; ord[1] = 2; ord[2] = 1;
`else
        ord[0] = 1; ord[1] = 2; ord[2] = 3;
`endif
        // Reset state and ready timing
        idle_inputs();
        tick();
        tick();
        check_all_zero("rst");
        check("rst_ready", 64'({alu_ready_o, lsu_ready_o, br_ready_o}), 64'd0);
        reset = 1'b0;
        check("ready_first_cycle", 64'({alu_ready_o, lsu_ready_o, br_ready_o}), 64'd0);
        tick();
        check("ready_after_reset", 64'({alu_ready_o, lsu_ready_o, br_ready_o}), 64'h7);

        // Single ALU result appears the next cycle
        wb_ready_i = 1'b1;
        check("idle_valid", 64'(wb_valid_o), 64'd0);
        drive(0, 4'd3, 6'd5, 32'h1234_5678, 1'b0);
        tick();
        idle_inputs();
        check("lat_valid", 64'(wb_valid_o), 64'd1);
        check("lat_tag", 64'(wb_tag_o), 64'd3);
        check("lat_rd", 64'(wb_rd_o), 64'd5);
        check("lat_val", 64'(wb_val_o), 64'h1234_5678);
        check("lat_src", 64'(wb_src_fu_o), 64'd0);
        check("lat_completed", 64'(wb_completed_o), 64'd1);
        tick();
        check("lat_drained", 64'(wb_valid_o), 64'd0);

        // Three sources in one cycle
        do_reset();
        wb_ready_i = 1'b1;
        for (int s = 0; s < 3; s++) drive(s, 4'(s + 1), 6'(s + 10), 32'(s + 1) * 32'h111, 1'b0);
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            check("arb_order_tag", 64'(wb_tag_o), 64'(ord[k]));
            check("arb_order_src", 64'(wb_src_fu_o), 64'(ord[k] - 1));
            tick();
        end
        check("arb_order_done", 64'(wb_valid_o), 64'd0);

        // Backpressure fills the ALU FIFO
        wb_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("bp_ready_before_push", 64'(alu_ready_o), 64'd1);
            drive(0, 4'(k + 4), 6'(k + 20), 32'hA000 + 32'(k), 1'b0);
            tick();
        end
        idle_inputs();
        check("bp_ready_full", 64'(alu_ready_o), 64'd0);
        check("bp_head_tag", 64'(wb_tag_o), 64'd4);
        tick();
        check("bp_hold_tag", 64'(wb_tag_o), 64'd4);
        check("bp_still_full", 64'(alu_ready_o), 64'd0);
        wb_ready_i = 1'b1;
        tick();
        check("bp_second_tag", 64'(wb_tag_o), 64'd5);
        check("bp_ready_reopen", 64'(alu_ready_o), 64'd1);
        tick();
        check("bp_third_tag", 64'(wb_tag_o), 64'd6);
        tick();
        check("bp_drained", 64'(wb_valid_o), 64'd0);

        // Mispredict flag, then an ALU write to preg 0
        drive(2, 4'd7, 6'd9, 32'hB0B0_0007, 1'b1);
        tick();
        idle_inputs();
        drive(0, 4'd8, 6'd0, 32'hDEAD_BEEF, 1'b0);
        check("br_src", 64'(wb_src_fu_o), 64'd2);
        check("br_mis", 64'(wb_mispredict_o), 64'd1);
        check("br_tag", 64'(wb_tag_o), 64'd7);
        tick();
        idle_inputs();
        check("alu_after_br_mis", 64'(wb_mispredict_o), 64'd0);
        check("alu_after_br_src", 64'(wb_src_fu_o), 64'd0);
        check("rd0_passthrough", 64'(wb_rd_o), 64'd0);
        check("rd0_val", 64'(wb_val_o), 64'hDEAD_BEEF);
        tick();

        // Flush with buffered packets and a concurrent LSU push
        wb_ready_i = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 4'(s + 1), 6'(s + 1), 32'hC000 + 32'(s), 1'b0);
        tick();
        idle_inputs();
        drive(0, 4'd4, 6'd4, 32'hC004, 1'b0);
        drive(2, 4'd6, 6'd6, 32'hC006, 1'b0);
        tick();
        idle_inputs();
        check("pre_flush_valid", 64'(wb_valid_o), 64'd1);
        flush_i = 1'b1;
        drive(1, 4'd5, 6'd5, 32'hC005, 1'b0);
        tick();
        idle_inputs();
        check("flush_valid", 64'(wb_valid_o), 64'd0);
        check("flush_completed", 64'(wb_completed_o), 64'd0);
        check("flush_ready", 64'({alu_ready_o, lsu_ready_o, br_ready_o}), 64'h7);
        wb_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("flush_no_more", 64'(wb_valid_o), 64'd0);
        end

        // Reset mid-operation
        wb_ready_i = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 4'(s + 9), 6'(s + 30), 32'hD000 + 32'(s), 1'b1);
        tick();
        idle_inputs();
        tick();
        check("pre_reset_valid", 64'(wb_valid_o), 64'd1);
        reset = 1'b1;
        tick();
        check_all_zero("midrst");
        check("midrst_ready", 64'({alu_ready_o, lsu_ready_o, br_ready_o}), 64'd0);
        reset = 1'b0;
        wb_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("midrst_no_more", 64'(wb_valid_o), 64'd0);
        end

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            idle_inputs();
            for (int s = 0; s < 3; s++) begin
                if ($urandom_range(0, 1) == 1)
                    drive(s, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 1)));
            end
            wb_ready_i = ($urandom_range(0, 9) < 7);
            flush_i = ($urandom_range(0, 49) == 0);
            tick();
        end

        // Drain
        idle_inputs();
        wb_ready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (wb_valid_o || exp_q_alu.size() != 0 || exp_q_lsu.size() != 0 || exp_q_br.size() != 0) tick();
        end
        check("drain_alu_q", 64'(exp_q_alu.size()), 64'd0);
        check("drain_lsu_q", 64'(exp_q_lsu.size()), 64'd0);
        check("drain_br_q", 64'(exp_q_br.size()), 64'd0);
        check("drain_valid", 64'(wb_valid_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
